mult_div_sequencer: RTL
=======================

// Module: mult_div_sequencer
// PURPOSE
//  Multi-cycle MULT/DIV engine and HI/LO register owner for the MIPS datapath.
//  Decodes ULAopcode from the ALU control, runs a WIDTH-step shift-add multiply
//  or restoring divide, and holds the processor via stall until the result is
//  written to HI/LO. Also serves MFHI/MFLO reads combinationally.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width; iteration count per op
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      current instruction is valid for this unit
//  ULAopcode  in   4      1000 MULT, 1001 DIV, 1010 MFLO, 1011 MFHI; others ignored
//  A          in   WIDTH  rs operand (dividend / multiplicand)
//  B          in   WIDTH  rt operand (divisor / multiplier)
//  stall      out  1      freeze PC/instruction while op in flight
//  done       out  1      one-cycle pulse: HI/LO just updated
//  div_zero   out  1      pulse with done when DIV had B==0
//  result     out  WIDTH  MFLO->LO, MFHI->HI, else 0 (combinational)
//  HI, LO     out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  - Reset: state IDLE, HI=LO=0, stall=0, done=0, div_zero=0. Reset mid-op
//    aborts; no done pulse; HI/LO forced 0.
//  - FSM IDLE -> MUL | DIV -> FIN -> IDLE.
//    IDLE: start & MULT -> MUL; start & DIV & B!=0 -> DIV; start & DIV & B==0
//    -> FIN (HI/LO unchanged, div_zero=1 in FIN). Other opcodes: stay IDLE.
//    MUL/DIV: exactly WIDTH cycles, one bit per cycle, 6-bit step counter;
//    HI/LO written on edge leaving last step -> FIN.
//    FIN: done=1 for one cycle, stall=0, start ignored (same instr still present).
//  - stall = (IDLE & start & op in {MULT,DIV}) | MUL | DIV. Combinational in
//    IDLE so the issuing cycle is already frozen. stall=0 in FIN.
//  - Latency (start cycle = 0): done in cycle WIDTH+1; div-by-zero done cycle 1.
//  - Signed: operands latched as magnitudes + sign bits at IDLE exit;
//    unsigned core; sign fix on write.
//    MULT: {HI,LO} = 2*WIDTH-bit signed product.
//    DIV: LO=quotient (trunc toward 0, sign=sA^sB), HI=remainder (sign=sA).
//    -2^(W-1) / -1: LO=2^(W-1) (wrap), HI=0.
//  - A/B may change after issue cycle; latched copies used.
//  - MFLO/MFHI never stall; they read HI/LO current value (in FIN: new value).
// CONFIGURATION
//  UNSIGNED_OPS_EN defined: ULAopcode 0011 MULTU, 0100 DIVU accepted; same FSM
//  and latency, no sign handling (operands unsigned).
//  Not defined: 0011/0100 ignored like any unknown code (no stall, no update).
// TESTING
//  1 rst=1 2 cycles -> HI=LO=0, stall=0, done=0, result=0.
//  2 MULT A=7 B=FFFFFFF9(-7)... use B=FFFFFFFD(-3) -> stall cycles 0..32,
//    done cycle 33, HI=FFFFFFFF LO=FFFFFFEB.
//  3 DIV A=FFFFFFEF(-17) B=5 -> done cycle 33, LO=FFFFFFFD, HI=FFFFFFFE.
//  4 DIV A=9 B=0 with HI=1,LO=2 -> done+div_zero cycle 1, HI=1 LO=2 kept.
//  5 MULT A=3 B=4, rst=1 at cycle 10 -> IDLE, stall=0, HI=LO=0, no done.
//  6 after test 2: MFLO -> result=FFFFFFEB, MFHI -> FFFFFFFF, stall=0;
//    with UNSIGNED_OPS_EN: MULTU FFFFFFFF*2 -> HI=1 LO=FFFFFFFE.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/DIV engine owning HI/LO; shift-add multiply and restoring divide, one bit per cycle.
// Define UNSIGNED_OPS_EN to also accept MULTU (0011) and DIVU (0100).
module mult_div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ULAopcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFLO = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1011;
`ifdef UNSIGNED_OPS_EN
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    state_t state, state_nx;

    logic [5:0]         cnt;
    logic               last;
    logic [WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
    logic               neg_res, neg_rem, dz;
    logic               op_mul, op_div, op_signed, sa, sb;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        op_mul    = (ULAopcode == OP_MULT);
        op_div    = (ULAopcode == OP_DIV);
        op_signed = 1'b1;
`ifdef UNSIGNED_OPS_EN
        if (ULAopcode == OP_MULTU) begin
            op_mul    = 1'b1;
            op_signed = 1'b0;
        end
        if (ULAopcode == OP_DIVU) begin
            op_div    = 1'b1;
            op_signed = 1'b0;
        end
`endif
        sa       = op_signed & A[WIDTH-1];
        sb       = op_signed & B[WIDTH-1];
        in_mag_a = sa ? -A : A;
        in_mag_b = sb ? -B : B;
    end

    // acc_hi/acc_lo are shared: partial product + multiplier, or remainder + dividend/quotient.
    always_comb begin
        last     = (cnt == 6'(WIDTH - 1));
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, mag_b});
        div_hi   = div_ge ? (div_sh[WIDTH-1:0] - mag_b) : div_sh[WIDTH-1:0];
        div_lo   = {acc_lo[WIDTH-2:0], div_ge};
        prod     = {mul_hi, mul_lo};
        prod_fix = neg_res ? -prod : prod;
        q_fix    = neg_res ? -div_lo : div_lo;
        r_fix    = neg_rem ? -div_hi : div_hi;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        case (state)
            IDLE: begin
                if (start && op_mul) begin
                    stall    = 1'b1;
                    state_nx = MUL;
                end else if (start && op_div) begin
                    stall    = 1'b1;
                    state_nx = (B == '0) ? FIN : DIV;
                end
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (last) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                div_zero = dz;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (state_nx != IDLE) begin
                        mag_a   <= in_mag_a;
                        mag_b   <= in_mag_b;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        dz      <= (state_nx == FIN);
                        cnt     <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= (state_nx == MUL) ? in_mag_b : in_mag_a;
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt + 6'd1;
                    if (last) {HI, LO} <= prod_fix;
                end
                DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt + 6'd1;
                    if (last) begin
                        HI <= r_fix;
                        LO <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (ULAopcode)
            OP_MFLO: result = LO;
            OP_MFHI: result = HI;
            default: result = '0;
        endcase
    end
endmodule
